// File: rtl/stream_demux.sv
// stream_demux: one-to-N valid/ready stream distributor.
// Each source beat is steered by src_dst_i into a one-entry registered slot
// per destination, so a stalled destination never blocks the others.
// Optional feature macro: STREAM_DEMUX_BCAST_EN (broadcast to all slots).
module stream_demux #(
  parameter  int N_SLAVE   = 4,
  parameter  int DATA_SIZE = 32,
  localparam int ID_W      = $clog2(N_SLAVE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 src_valid_i,
  output logic                 src_ready_o,
  input  logic [DATA_SIZE-1:0] src_data_i,
  input  logic [ID_W-1:0]      src_dst_i,
  input  logic                 src_bcast_i,
  output logic                 dst_valid_o [N_SLAVE],
  input  logic                 dst_ready_i [N_SLAVE],
  output logic [DATA_SIZE-1:0] dst_data_o  [N_SLAVE],
  output logic [7:0]           drop_cnt_o
);

  logic [N_SLAVE-1:0]   valid;
  logic [DATA_SIZE-1:0] data [N_SLAVE];
  logic [N_SLAVE-1:0]   free;
  logic [N_SLAVE-1:0]   sel;
  logic [N_SLAVE-1:0]   load;
  logic                 in_range;
  logic                 unicast_ready;
  logic                 src_ready;
  logic                 fire;
  logic                 drop;
  logic [7:0]           drop_cnt;

  // An out-of-range ID can only occur when N_SLAVE is not a power of two.
  generate
    if ((1 << ID_W) == N_SLAVE) begin : g_pow2
      assign in_range = 1'b1;
    end else begin : g_npow2
      assign in_range = (src_dst_i < ID_W'(N_SLAVE));
    end
  endgenerate

  // Per-slot free flag (empty or draining now) and one-hot destination select.
  always_comb begin
    free = '0;
    sel  = '0;
    for (int i = 0; i < N_SLAVE; i++) begin
      free[i] = !valid[i] | dst_ready_i[i];
      sel[i]  = in_range && (src_dst_i == ID_W'(i));
    end
    unicast_ready = in_range ? |(sel & free) : 1'b1;
  end

`ifdef STREAM_DEMUX_BCAST_EN
  // Broadcast waits until every slot can take the beat so it is never split.
  always_comb begin
    src_ready = src_bcast_i ? &free : unicast_ready;
    fire      = src_valid_i & src_ready;
    load      = '0;
    if (fire) begin
      load = src_bcast_i ? '1 : sel;
    end
    drop      = fire & !src_bcast_i & !in_range;
  end
`else
  logic unused_bcast;
  assign unused_bcast = src_bcast_i;

  // Unicast only: ready follows the selected slot, out-of-range beats are sunk.
  always_comb begin
    src_ready = unicast_ready;
    fire      = src_valid_i & src_ready;
    load      = fire ? sel : '0;
    drop      = fire & !in_range;
  end
`endif

  // Slot registers: a fill wins over a drain, so drain+fill keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < N_SLAVE; i++) begin
        data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SLAVE; i++) begin
        if (load[i]) begin
          valid[i] <= 1'b1;
          data[i]  <= src_data_i;
        end else if (dst_ready_i[i]) begin
          valid[i] <= 1'b0;
        end
      end
    end
  end

  // Saturating count of beats discarded for an out-of-range destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Outputs come straight from the slot registers.
  always_comb begin
    for (int i = 0; i < N_SLAVE; i++) begin
      dst_valid_o[i] = valid[i];
      dst_data_o[i]  = data[i];
    end
  end

  assign src_ready_o = src_ready;
  assign drop_cnt_o  = drop_cnt;

endmodule
